mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 27 ++
 rtl/mem_arbiter.sv | 87 ++++++++
 tb/tb_mem_arbiter.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Requester-side handshake bundle for mem_arbiter: two identical request/ack
// channels, each carrying direction, address, write data and read data.
interface mem_arbiter_if;
  logic       req0;
  logic       wr0;
  logic [7:0] addr0;
  logic [7:0] wdata0;
  logic       ack0;
  logic [7:0] rdata0;

  logic       req1;
  logic       wr1;
  logic [7:0] addr1;
  logic [7:0] wdata1;
  logic       ack1;
  logic [7:0] rdata1;

  modport master (
    output req0, wr0, addr0, wdata0, req1, wr1, addr1, wdata1,
    input  ack0, rdata0, ack1, rdata1
  );

  modport slave (
    input  req0, wr0, addr0, wdata0, req1, wr1, addr1, wdata1,
    output ack0, rdata0, ack1, rdata1
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of a 256x8 single-port memory.
// Each transaction is IDLE -> ACCESS (one memory cycle) -> ACK (one-cycle ack).
module mem_arbiter (
  input  logic        clk,
  input  logic        rst,
  mem_arbiter_if.slave bus,
  output logic [7:0]  memory_address,
  output logic        memory_rd,
  output logic        memory_wr,
  inout  wire  [7:0]  memory_data,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

  state_t     state;
  logic       grant;
  logic       last;
  logic       lat_wr;
  logic [7:0] lat_wdata;
  logic       win1;

  // On a tie the requester that was not served last wins; a lone requester always wins.
  assign win1 = bus.req1 && (!bus.req0 || !last);

  // The bus is driven only while the registered write strobe is high, so reset releases it at once.
  assign memory_data = memory_wr ? lat_wdata : 8'hzz;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      grant          <= 1'b0;
      last           <= 1'b1;
      lat_wr         <= 1'b0;
      lat_wdata      <= 8'h00;
      memory_address <= 8'h00;
      memory_rd      <= 1'b0;
      memory_wr      <= 1'b0;
      busy           <= 1'b0;
      bus.ack0       <= 1'b0;
      bus.ack1       <= 1'b0;
      bus.rdata0     <= 8'h00;
      bus.rdata1     <= 8'h00;
    end else begin
      bus.ack0 <= 1'b0;
      bus.ack1 <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req0 || bus.req1) begin
            state          <= ACCESS;
            busy           <= 1'b1;
            grant          <= win1;
            last           <= win1;
            lat_wr         <= win1 ? bus.wr1 : bus.wr0;
            lat_wdata      <= win1 ? bus.wdata1 : bus.wdata0;
            memory_address <= win1 ? bus.addr1 : bus.addr0;
            memory_rd      <= win1 ? !bus.wr1 : !bus.wr0;
            memory_wr      <= win1 ? bus.wr1 : bus.wr0;
          end
        end
        ACCESS: begin
          state     <= ACK;
          memory_rd <= 1'b0;
          memory_wr <= 1'b0;
          if (!lat_wr) begin
            if (grant) bus.rdata1 <= memory_data;
            else       bus.rdata0 <= memory_data;
          end
          bus.ack0 <= !grant;
          bus.ack1 <= grant;
        end
        ACK: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          memory_rd <= 1'b0;
          memory_wr <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a behavioural 256x8 memory on the shared bus,
// a reference RAM model, and a scoreboard of expected acks checked by a monitor.
module tb_mem_arbiter;

  logic       clk;
  logic       rst;
  logic [7:0] memory_address;
  logic       memory_rd;
  logic       memory_wr;
  wire  [7:0] memory_data;
  logic       busy;

  mem_arbiter_if bus();

  mem_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .memory_address (memory_address),
    .memory_rd      (memory_rd),
    .memory_wr      (memory_wr),
    .memory_data    (memory_data),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural memory: preloaded with RAM[a] = a + 1 on its first clock.
  logic [7:0] ram [256];
  logic       loaded = 1'b0;
  assign memory_data = memory_rd ? ram[memory_address] : 8'hzz;
  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 256; i++) ram[i] <= 8'(i + 1);
      loaded <= 1'b1;
    end else if (memory_wr) begin
      ram[memory_address] <= memory_data;
    end
  end

  typedef struct packed {
    logic       id;
    logic [7:0] r0;
    logic [7:0] r1;
  } exp_t;

  exp_t       sb [$];
  logic [7:0] model [256];
  logic [7:0] m_rdata [2];
  int         n_cmp = 0;
  int         n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every ack is matched against the oldest expected completion.
  always @(negedge clk) begin
    if (bus.ack0 || bus.ack1) begin
      check("single_ack", 32'(bus.ack0 & bus.ack1), 32'd0);
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $error("FAIL unexpected_ack: observed ack0=%0b ack1=%0b expected none", bus.ack0, bus.ack1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("ack_id", 32'(bus.ack1), 32'(e.id));
        check("rdata0", 32'(bus.rdata0), 32'(e.r0));
        check("rdata1", 32'(bus.rdata1), 32'(e.r1));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit id, input bit req, input bit wr, input logic [7:0] addr,
                       input logic [7:0] wdata);
    if (id) begin
      bus.req1 = req; bus.wr1 = wr; bus.addr1 = addr; bus.wdata1 = wdata;
    end else begin
      bus.req0 = req; bus.wr0 = wr; bus.addr0 = addr; bus.wdata0 = wdata;
    end
  endtask

  task automatic expect_done(input bit id, input bit wr, input logic [7:0] addr,
                             input logic [7:0] wdata);
    if (wr) model[addr] = wdata;
    else    m_rdata[id] = model[addr];
    sb.push_back('{id: id, r0: m_rdata[0], r1: m_rdata[1]});
  endtask

  // One complete transaction from a lone requester, checked cycle by cycle.
  task automatic txn(input bit id, input bit wr, input logic [7:0] addr,
                     input logic [7:0] wdata, input bit drop_early);
    drive(id, 1'b1, wr, addr, wdata);
    tick();
    if (drop_early) drive(id, 1'b0, ~wr, 8'h77, 8'h3C);
    check("acc_busy", 32'(busy), 32'd1);
    check("acc_addr", 32'(memory_address), 32'(addr));
    check("acc_rd", 32'(memory_rd), 32'(!wr));
    check("acc_wr", 32'(memory_wr), 32'(wr));
    if (wr) check("acc_wdata", 32'(memory_data), 32'(wdata));
    expect_done(id, wr, addr, wdata);
    tick();
    check("ack_rd_low", 32'(memory_rd | memory_wr), 32'd0);
    drive(id, 1'b0, wr, addr, wdata);
    tick();
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_acks", 32'(bus.ack0 | bus.ack1), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    for (int i = 0; i < 256; i++) model[i] = 8'(i + 1);
    m_rdata[0] = 8'h00;
    m_rdata[1] = 8'h00;

    // Reset values are visible before any clock edge.
    #2;
    check("rst_ack0", 32'(bus.ack0), 32'd0);
    check("rst_ack1", 32'(bus.ack1), 32'd0);
    check("rst_rdata0", 32'(bus.rdata0), 32'd0);
    check("rst_rdata1", 32'(bus.rdata1), 32'd0);
    check("rst_mem_rd", 32'(memory_rd), 32'd0);
    check("rst_mem_wr", 32'(memory_wr), 32'd0);
    check("rst_mem_addr", 32'(memory_address), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Ten quiet cycles.
    for (int i = 0; i < 10; i++) begin
      tick();
      check("quiet_busy", 32'(busy), 32'd0);
      check("quiet_rd_wr", 32'(memory_rd | memory_wr), 32'd0);
    end

    // Read of 0x10 by requester 0.
    txn(1'b0, 1'b0, 8'h10, 8'h00, 1'b0);
    check("r0_rdata0_held", 32'(bus.rdata0), 32'h11);
    check("r0_rdata1_zero", 32'(bus.rdata1), 32'h00);

    // Reset in the middle of a write ACCESS aborts it.
    drive(1'b0, 1'b1, 1'b1, 8'h20, 8'hFF);
    tick();
    check("abort_wr_high", 32'(memory_wr), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("abort_wr_low", 32'(memory_wr), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_addr", 32'(memory_address), 32'd0);
    check("abort_rdata0", 32'(bus.rdata0), 32'd0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    rst = 1'b0;
    m_rdata[0] = 8'h00;
    m_rdata[1] = 8'h00;
    repeat (3) tick();
    check("abort_no_ack", 32'(sb.size()), 32'd0);
    txn(1'b0, 1'b0, 8'h20, 8'h00, 1'b0);

    // Requester 0 drops its request (and scrambles its inputs) right after the grant.
    txn(1'b0, 1'b0, 8'h05, 8'h00, 1'b1);
    check("drop_rdata0", 32'(bus.rdata0), 32'h06);

    // Requester 1 write then read back.
    txn(1'b1, 1'b1, 8'h20, 8'hA5, 1'b0);
    check("wr_keeps_rdata1", 32'(bus.rdata1), 32'h00);
    txn(1'b1, 1'b0, 8'h20, 8'h00, 1'b0);
    check("rd_back_rdata1", 32'(bus.rdata1), 32'hA5);

    // Both requesters held from reset release: grants alternate 0,1,0,1.
    rst = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 8'h01, 8'h00);
    drive(1'b1, 1'b1, 1'b0, 8'h02, 8'h00);
    tick();
    m_rdata[0] = 8'h00;
    m_rdata[1] = 8'h00;
    rst = 1'b0;
    expect_done(1'b0, 1'b0, 8'h01, 8'h00);
    expect_done(1'b1, 1'b0, 8'h02, 8'h00);
    expect_done(1'b0, 1'b0, 8'h01, 8'h00);
    expect_done(1'b1, 1'b0, 8'h02, 8'h00);
    for (int k = 0; k < 12; k++) begin
      logic exp_ack;
      tick();
      exp_ack = (k % 3 == 1);
      check("rr_ack_cadence", 32'(bus.ack0 | bus.ack1), 32'(exp_ack));
    end
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (4) tick();
    check("rr_busy_done", 32'(busy), 32'd0);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
